// File: rtl/input_layer_fifo.sv
// ============================================================================
// input_layer_fifo
//
// Buffered input stage of the array neural network. Each NCH-lane input
// vector is converted lane by lane from the external signed fixed-point
// format to the network format. The conversion rounds half up and
// saturates. Converted vectors are held in a DEPTH-entry first-word
// fall-through FIFO until the first hidden layer takes them.
//
// Parameters
//   DWIDTH  network data width per lane (signed)
//   frac    network fraction bits
//   IWIDTH  external sample width per lane (signed)
//   IFRAC   external fraction bits
//   NCH     number of lanes (>= 1)
//   DEPTH   FIFO entries (power of two, >= 2)
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous active-low reset
//   in_valid   input vector valid
//   in_ready   block can accept a vector (registered count only)
//   in_data    lane k at [k*IWIDTH +: IWIDTH]
//   out_valid  head vector valid (registered count only)
//   out_ready  downstream accepts the head vector
//   out_data   lane k at [k*DWIDTH +: DWIDTH], zero while empty
//   count      number of stored vectors
//   sat_flag   sticky, a lane saturated on an accepted write
//   clr_sat    clears sat_flag (a simultaneous new saturation wins)
// ============================================================================
module input_layer_fifo #(
    parameter int DWIDTH = 32,
    parameter int frac   = 24,
    parameter int IWIDTH = 16,
    parameter int IFRAC  = 8,
    parameter int NCH    = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NCH*IWIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NCH*DWIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       sat_flag,
    input  logic                       clr_sat
);

    // A positive shift scales up. A negative shift scales down with rounding.
    localparam int S    = frac - IFRAC;
    localparam int SABS = (S < 0) ? -S : S;

    // This width holds the sign-extended sample after the full shift or the
    // rounding add. It also holds both saturation limits. No intermediate
    // value can overflow it.
    localparam int WA = IWIDTH + SABS + 2;
    localparam int WW = (WA > DWIDTH + 2) ? WA : DWIDTH + 2;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic signed [WW-1:0] MAXV = {{(WW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] MINV = {{(WW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    logic [NCH*DWIDTH-1:0] conv_data;
    logic [NCH-1:0]        lane_sat;
    logic                  any_sat;

    logic [NCH*DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;

    // Per-lane format conversion. It is purely combinational and works on
    // the raw input, so the FIFO stores vectors that are already converted.
    for (genvar k = 0; k < NCH; k++) begin : g_lane
        logic [IWIDTH-1:0]     raw;
        logic signed [WW-1:0]  ext;
        logic signed [WW-1:0]  scaled;

        assign raw = in_data[k*IWIDTH +: IWIDTH];
        assign ext = {{(WW-IWIDTH){raw[IWIDTH-1]}}, raw};

        if (S >= 0) begin : g_up
            assign scaled = ext <<< S;
        end else begin : g_down
            // Adding half an output LSB before the arithmetic shift gives
            // round half up, toward +infinity on exact ties.
            localparam int SH = -S;
            logic signed [WW-1:0] rnd;
            assign rnd    = {{(WW-1){1'b0}}, 1'b1} <<< (SH - 1);
            assign scaled = (ext + rnd) >>> SH;
        end

        assign lane_sat[k] = (scaled > MAXV) || (scaled < MINV);
        assign conv_data[k*DWIDTH +: DWIDTH] =
            (scaled > MAXV) ? MAXV[DWIDTH-1:0] :
            (scaled < MINV) ? MINV[DWIDTH-1:0] :
                              scaled[DWIDTH-1:0];
    end

    assign any_sat = |lane_sat;

    // The handshakes depend only on the registered count. This keeps
    // out_ready from reaching in_ready combinationally.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // First-word fall-through head. Stale memory is masked while empty.
    assign out_data = out_valid ? mem[rd_ptr] : '0;

    // Storage is not reset. An empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= conv_data;
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // naturally. Push while full and pop while empty are impossible because
    // push and pop are already qualified by in_ready and out_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky saturation indicator. Only accepted writes can set it. A new
    // saturation takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag <= 1'b0;
        end else if (push && any_sat) begin
            sat_flag <= 1'b1;
        end else if (clr_sat) begin
            sat_flag <= 1'b0;
        end
    end

endmodule
